brick_scan_controller: RTL and testbench

Sequences the brick collision check once per game tick. It walks the brick RAM, presents each brick word to the collision detector, and qualifies the detector with its enable. On the first reported hit it erases that brick and reports the collision type to the ball-motion logic. It sits between the frame-tick/ball-update FSM, the brick RAM and the collision detector.

---
 rtl/brick_scan_controller.sv | 119 +++++++++++
 tb/tb_brick_scan_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/brick_scan_controller.sv
// brick_scan_controller: per-tick brick RAM walk feeding the collision detector;
// erases the first colliding brick and reports its collision type.
module brick_scan_controller #(
    parameter int NUM_BRICKS = 20,
    parameter int ADDR_W     = 5,
    parameter int ZONE_Y     = 34
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              load_level,
    input  logic [6:0]        ball_y,
    output logic [ADDR_W-1:0] brick_addr,
    input  logic [18:0]       brick_rdata,
    output logic              brick_we,
    output logic [18:0]       brick_wdata,
    output logic [18:0]       brick_out,
    output logic              enable_brick_detector,
    input  logic [1:0]        brick_collision,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [1:0]        hit_type,
    output logic [ADDR_W-1:0] hit_addr,
    output logic [ADDR_W:0]   bricks_left,
    output logic              level_clear
);
    typedef enum logic [2:0] {IDLE, READ, LOAD, CHECK, EVAL, ERASE, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BRICKS - 1);
    localparam logic [ADDR_W:0]   FULL = (ADDR_W + 1)'(NUM_BRICKS);
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, haddr_q, haddr_d;
    logic [18:0]         bout_q, bout_d;
    logic                hit_q, hit_d;
    logic [1:0]          type_q, type_d;
    logic [ADDR_W:0]     left_q, left_d;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        haddr_d = haddr_q;
        bout_d  = bout_q;
        hit_d   = hit_q;
        type_d  = type_q;
        left_d  = left_q;
        unique case (state_q)
            IDLE: begin
                if (load_level) left_d = FULL;
                if (start) begin
                    hit_d   = 1'b0;
                    type_d  = 2'b00;
                    haddr_d = '0;
                    if (int'(ball_y) < ZONE_Y) begin
                        addr_d  = '0;
                        state_d = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ:  state_d = LOAD;
            LOAD: begin
                bout_d  = brick_rdata;
                state_d = CHECK;
            end
            CHECK: state_d = EVAL;
            EVAL: begin
                if (brick_collision != 2'b00) begin
                    hit_d   = 1'b1;
                    type_d  = brick_collision;
                    haddr_d = addr_q;
                    state_d = ERASE;
                end else if (addr_q == LAST) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = READ;
                end
            end
            ERASE: begin
                left_d  = (left_q == '0) ? '0 : left_q - 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            haddr_q <= '0;
            bout_q  <= '0;
            hit_q   <= 1'b0;
            type_q  <= 2'b00;
            left_q  <= FULL;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            haddr_q <= haddr_d;
            bout_q  <= bout_d;
            hit_q   <= hit_d;
            type_q  <= type_d;
            left_q  <= left_d;
        end
    end
    // Erase keeps position bits and clears only the colour field.
    assign brick_we              = state_q == ERASE;
    assign brick_wdata           = brick_we ? {bout_q[18:3], 3'b000} : '0;
    assign enable_brick_detector = state_q == CHECK;
    assign busy                  = state_q != IDLE;
    assign done                  = state_q == DONE;
    assign brick_addr            = addr_q;
    assign brick_out             = bout_q;
    assign hit                   = hit_q;
    assign hit_type              = type_q;
    assign hit_addr              = haddr_q;
    assign bricks_left           = left_q;
    assign level_clear           = left_q == '0;
endmodule

// File: tb/tb_brick_scan_controller.sv
// tb_brick_scan_controller: directed scans with a RAM and registered detector model;
// expected scan results are queued at start and checked by a done monitor.
module tb_brick_scan_controller;
    logic        clock = 1'b0, resetn = 1'b0, start = 1'b0, load_level = 1'b0;
    logic [6:0]  ball_y = '0;
    logic [4:0]  brick_addr, hit_addr;
    logic [18:0] brick_rdata, brick_wdata, brick_out;
    logic        brick_we, enable_brick_detector, busy, done, hit, level_clear;
    logic [1:0]  brick_collision, hit_type;
    logic [5:0]  bricks_left;

    brick_scan_controller dut (
        .clock(clock), .resetn(resetn), .start(start), .load_level(load_level),
        .ball_y(ball_y), .brick_addr(brick_addr), .brick_rdata(brick_rdata),
        .brick_we(brick_we), .brick_wdata(brick_wdata), .brick_out(brick_out),
        .enable_brick_detector(enable_brick_detector), .brick_collision(brick_collision),
        .busy(busy), .done(done), .hit(hit), .hit_type(hit_type), .hit_addr(hit_addr),
        .bricks_left(bricks_left), .level_clear(level_clear)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       h;
        logic [1:0] t;
        logic [4:0] a;
        logic [5:0] bl;
        int         dc;
    } exp_t;
    exp_t sb[$];
    exp_t got;

    int checks = 0, failures = 0, cyc = 0;
    int en_cnt = 0, wr_cnt = 0, moved_cnt = 0;
    logic [4:0]  wr_addr = '0;
    logic [18:0] wr_data = '0;
    logic [18:0] mem [32];
    logic [1:0]  coll_tab [32];
    logic        mem_init = 1'b0;

    function automatic logic [18:0] brick_word(int i);
        return {8'(i * 8), 1'b0, 7'(i), 3'd2};
    endfunction

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous-read brick RAM
    always @(posedge clock) begin
        if (mem_init) for (int i = 0; i < 32; i++) mem[i] <= brick_word(i);
        else if (brick_we) mem[brick_addr] <= brick_wdata;
        brick_rdata <= mem[brick_addr];
    end

    // Registered detector: colour-0 bricks never collide
    always @(posedge clock)
        brick_collision <= (enable_brick_detector && brick_out[2:0] != 3'd0) ? coll_tab[brick_addr] : 2'b00;

    always @(negedge clock) begin
        if (brick_we) begin
            wr_cnt++;
            wr_addr = brick_addr;
            wr_data = brick_wdata;
        end
        if (enable_brick_detector) en_cnt++;
        if (brick_addr != 5'd0) moved_cnt++;
        if (done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                got = sb.pop_front();
                chk("done_cycle", cyc, got.dc);
                chk("hit", int'(hit), int'(got.h));
                chk("hit_type", int'(hit_type), int'(got.t));
                chk("hit_addr", int'(hit_addr), int'(got.a));
                chk("bricks_left", int'(bricks_left), int'(got.bl));
            end
        end
    end

    task automatic init_mem();
        @(negedge clock) mem_init = 1'b1;
        @(negedge clock) mem_init = 1'b0;
    endtask

    task automatic do_start(logic [6:0] y, int lat, logic h, logic [1:0] t, logic [4:0] a, logic [5:0] bl);
        exp_t e;
        @(negedge clock);
        ball_y = y;
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        e.h = h; e.t = t; e.a = a; e.bl = bl;
        e.dc = cyc - 1 + lat;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (busy) chk("scan_timeout", 1, 0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int en0, wr0, mv0;
        for (int i = 0; i < 32; i++) coll_tab[i] = 2'b00;
        init_mem();
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_addr", int'(brick_addr), 0);
        chk("rst_we", int'(brick_we), 0);
        chk("rst_brick_out", int'(brick_out), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_bricks_left", int'(bricks_left), 20);
        chk("rst_level_clear", int'(level_clear), 0);
        resetn = 1'b1;
        @(negedge clock) load_level = 1'b1;
        @(negedge clock) load_level = 1'b0;

        // Out of zone, plus a start coinciding with done must be ignored
        en0 = en_cnt; mv0 = moved_cnt;
        do_start(7'd50, 1, 1'b0, 2'b00, 5'd0, 6'd20);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        chk("start_with_done_ignored", int'(busy), 0);
        wait_idle();
        chk("ooz_enables", en_cnt - en0, 0);
        chk("ooz_addr_moved", moved_cnt - mv0, 0);

        // Full scan, no collisions
        en0 = en_cnt; wr0 = wr_cnt;
        do_start(7'd20, 81, 1'b0, 2'b00, 5'd0, 6'd20);
        wait_idle();
        chk("full_enables", en_cnt - en0, 20);
        chk("full_writes", wr_cnt - wr0, 0);

        // Single hit at address 5
        coll_tab[5] = 2'b01;
        en0 = en_cnt; wr0 = wr_cnt;
        do_start(7'd20, 26, 1'b1, 2'b01, 5'd5, 6'd19);
        wait_idle();
        chk("h5_writes", wr_cnt - wr0, 1);
        chk("h5_wr_addr", int'(wr_addr), 5);
        chk("h5_wr_data", int'(wr_data), int'(brick_word(5) & 19'h7FFF8));
        chk("h5_enables", en_cnt - en0, 6);
        coll_tab[5] = 2'b00;

        // Two colliders: first wins, scan stops
        coll_tab[3] = 2'b10;
        coll_tab[7] = 2'b11;
        en0 = en_cnt; wr0 = wr_cnt;
        do_start(7'd20, 18, 1'b1, 2'b10, 5'd3, 6'd18);
        wait_idle();
        chk("h3_enables", en_cnt - en0, 4);
        chk("h3_writes", wr_cnt - wr0, 1);
        chk("h3_wr_addr", int'(wr_addr), 3);
        coll_tab[3] = 2'b00;
        coll_tab[7] = 2'b00;

        // Restart attempt mid-scan, then reset
        coll_tab[2] = 2'b01;
        wr0 = wr_cnt;
        @(negedge clock);
        ball_y = 7'd20;
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (2) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(posedge clock);
        #1 chk("restart_ignored_addr", int'(brick_addr), 2);
        resetn = 1'b0;
        @(posedge clock);
        #1 chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_bricks_left", int'(bricks_left), 20);
        repeat (4) @(negedge clock);
        chk("mid_rst_writes", wr_cnt - wr0, 0);
        chk("mid_rst_hit", int'(hit), 0);
        resetn = 1'b1;
        coll_tab[2] = 2'b00;

        // Erase every brick, one per scan
        init_mem();
        for (int i = 0; i < 32; i++) coll_tab[i] = 2'b01;
        for (int k = 0; k < 20; k++) begin
            do_start(7'd10, 4 * k + 6, 1'b1, 2'b01, 5'(k), 6'(19 - k));
            wait_idle();
        end
        chk("all_bricks_left", int'(bricks_left), 0);
        chk("all_level_clear", int'(level_clear), 1);
        @(negedge clock) load_level = 1'b1;
        @(negedge clock) load_level = 1'b0;
        chk("reload_bricks_left", int'(bricks_left), 20);
        chk("reload_level_clear", int'(level_clear), 0);

        repeat (3) @(negedge clock);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
